// File: rtl/oh_fifo_wptr_ctrl.sv
// Write-side pointer controller for the async FIFO: binary/Gray write pointer,
// read-pointer synchronizer, full/occupancy/overflow flags. Optional almost_full via OH_FIFO_AFULL_EN.
module oh_fifo_wptr_ctrl #(
  parameter int AW          = 4,
  parameter int AFULL_LEVEL = (1 << AW) - 2
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          wr_en,
  input  logic [AW:0]   rd_ptr_gray,
  input  logic          ovf_clr,
  output logic [AW-1:0] wr_addr,
  output logic          wr_push,
  output logic [AW:0]   wr_ptr_gray,
  output logic          full,
  output logic          almost_full,
  output logic [AW:0]   wr_count,
  output logic          overflow
);

  localparam logic [AW:0] DEPTH    = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] AFULL_TH = AFULL_LEVEL[AW:0];

  logic [AW:0] wr_ptr_bin;
  logic [AW:0] wr_ptr_bin_next;
  logic [AW:0] rq1;
  logic [AW:0] rq2;
  logic [AW:0] rd_bin;
  logic [AW:0] cnt_next;

  function automatic logic [AW:0] bin2gray(input logic [AW:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
    logic [AW:0] b;
    b[AW] = g[AW];
    for (int i = AW - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Stage 0: combinational push decision, next pointer and occupancy
  assign wr_push         = wr_en & ~full & nreset;
  assign wr_addr         = wr_ptr_bin[AW-1:0];
  assign wr_ptr_bin_next = wr_ptr_bin + {{AW{1'b0}}, wr_push};
  assign rd_bin          = gray2bin(rq2);
  assign cnt_next        = wr_ptr_bin_next - rd_bin;

  // Stage 1: registered pointers, synchronizer and status flags
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wr_ptr_bin  <= '0;
      wr_ptr_gray <= '0;
      rq1         <= '0;
      rq2         <= '0;
      wr_count    <= '0;
      full        <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      rq1         <= rd_ptr_gray;
      rq2         <= rq1;
      wr_ptr_bin  <= wr_ptr_bin_next;
      wr_ptr_gray <= bin2gray(wr_ptr_bin_next);
      wr_count    <= cnt_next;
      full        <= (cnt_next == DEPTH);
      if (wr_en && full) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

`ifdef OH_FIFO_AFULL_EN
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      almost_full <= 1'b0;
    end else begin
      almost_full <= (cnt_next >= AFULL_TH);
    end
  end
`else
  logic unused_afull_th;
  assign unused_afull_th = ^AFULL_TH;
  assign almost_full     = 1'b0;
`endif

endmodule
